// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit: single-clock request/acknowledge bus sequencer owning PC and SP.
// Latency: accept -> strobes next cycle; zero-wait ack -> rsp_valid 2 cycles after accept; JUMP 1 cycle.
// Backpressure: cmd_ready only in IDLE; bus waits for ack (optional timeout); rsp has no backpressure.
//
// Ports: clk/reset (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata command in;
//        rsp_valid/rsp_data/rsp_err response out; pc/sp state out;
//        bus_addr/bus_wdata/bus_rd/bus_wr/bus_io to device, bus_rdata/bus_ack from device.
module cpu_bus_unit #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  SP_INIT  = {ADDR_W{1'b1}},
    parameter int                 MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic              bus_io,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam logic [2:0] OP_FETCH = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;
    localparam logic [2:0] OP_IN    = 3'd5;
    localparam logic [2:0] OP_OUT   = 3'd6;
    localparam logic [2:0] OP_JUMP  = 3'd7;

    localparam int                WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W:0]   WAIT_LIM = MAX_WAIT[WAIT_W:0];
    localparam logic [WAIT_W:0]   ONE_W    = 1;
    localparam logic [ADDR_W-1:0] ONE_A    = 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_op;
    logic [WAIT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]   r_pc, r_sp, r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata, r_rsp_data;
    logic                r_bus_rd, r_bus_wr, r_bus_io, r_rsp_valid, r_rsp_err;

    logic                w_accept, w_done_ack, w_done_tmo;
    logic [WAIT_W:0]     w_wait_inc;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_rd, w_wr, w_io;

    // Count this REQ cycle as one more unacknowledged wait.
    assign w_wait_inc = {1'b0, r_wait} + ONE_W;

    // Command decode: bus address and strobe kind for the op being accepted.
    always_comb begin
        w_addr = cmd_addr;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_io   = 1'b0;
        case (cmd_op)
            OP_FETCH: begin w_addr = r_pc;         w_rd = 1'b1; end
            OP_LOAD:  begin                         w_rd = 1'b1; end
            OP_STORE: begin                         w_wr = 1'b1; end
            OP_PUSH:  begin w_addr = r_sp;         w_wr = 1'b1; end
            OP_POP:   begin w_addr = r_sp + ONE_A; w_rd = 1'b1; end
            OP_IN:    begin w_rd = 1'b1; w_io = 1'b1; end
            OP_OUT:   begin w_wr = 1'b1; w_io = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ack  = 1'b0;
        w_done_tmo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && reset) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_op == OP_JUMP) ? S_RSP : S_REQ;
                end
            end
            S_REQ: begin
                // A late ack on the final wait cycle still wins over the timeout.
                if (bus_ack) begin
                    w_done_ack  = 1'b1;
                    w_state_nxt = S_RSP;
                end else if ((MAX_WAIT != 0) && (w_wait_inc == WAIT_LIM)) begin
                    w_done_tmo  = 1'b1;
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op        <= OP_FETCH;
            r_wait      <= '0;
            r_pc        <= '0;
            r_sp        <= SP_INIT;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_rd    <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_io    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= (w_state_nxt == S_RSP);
            if (w_accept) begin
                r_op <= cmd_op;
                if (cmd_op == OP_JUMP) begin
                    r_pc      <= cmd_addr;
                    r_rsp_err <= 1'b0;
                end else begin
                    r_bus_addr  <= w_addr;
                    r_bus_wdata <= cmd_wdata;
                    r_bus_rd    <= w_rd;
                    r_bus_wr    <= w_wr;
                    r_bus_io    <= w_io;
                    r_wait      <= '0;
                end
            end else if (w_done_ack) begin
                r_bus_rd   <= 1'b0;
                r_bus_wr   <= 1'b0;
                r_bus_io   <= 1'b0;
                r_rsp_err  <= 1'b0;
                r_rsp_data <= r_bus_rd ? bus_rdata : '0;
                if (r_op == OP_FETCH) r_pc <= r_pc + ONE_A;
                if (r_op == OP_PUSH)  r_sp <= r_sp - ONE_A;
                if (r_op == OP_POP)   r_sp <= r_sp + ONE_A;
            end else if (w_done_tmo) begin
                r_bus_rd   <= 1'b0;
                r_bus_wr   <= 1'b0;
                r_bus_io   <= 1'b0;
                r_rsp_err  <= 1'b1;
                r_rsp_data <= '0;
            end else if (r_state == S_REQ) begin
                r_wait <= w_wait_inc[WAIT_W-1:0];
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && reset;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign pc        = r_pc;
    assign sp        = r_sp;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_rd    = r_bus_rd;
    assign bus_wr    = r_bus_wr;
    assign bus_io    = r_bus_io;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb_cpu_bus_unit: randomized bench for cpu_bus_unit with a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cpu_bus_unit;

    localparam int MAXW = 15;
    localparam logic [2:0] OP_FETCH = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3,
                           OP_POP = 3'd4, OP_IN = 3'd5, OP_OUT = 3'd6, OP_JUMP = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 8-bit data, 8-bit address.
    logic       rst_a, cv_a, crdy_a, rv_a, rerr_a, rd_a, wr_a, io_a, ack_a;
    logic [2:0] op_a;
    logic [7:0] addr_a, wd_a, rdat_a, pc_a, sp_a, baddr_a, bwd_a, brd_a;

    cpu_bus_unit #(.DATA_W(8), .ADDR_W(8), .MAX_WAIT(MAXW)) u_a (
        .clk(clk), .reset(rst_a), .cmd_valid(cv_a), .cmd_ready(crdy_a), .cmd_op(op_a),
        .cmd_addr(addr_a), .cmd_wdata(wd_a), .rsp_valid(rv_a), .rsp_data(rdat_a),
        .rsp_err(rerr_a), .pc(pc_a), .sp(sp_a), .bus_addr(baddr_a), .bus_wdata(bwd_a),
        .bus_rd(rd_a), .bus_wr(wr_a), .bus_io(io_a), .bus_rdata(brd_a), .bus_ack(ack_a));

    // Instance B: 16-bit data, 12-bit address.
    logic        rst_b, cv_b, crdy_b, rv_b, rerr_b, rd_b, wr_b, io_b, ack_b;
    logic [2:0]  op_b;
    logic [11:0] addr_b, pc_b, sp_b, baddr_b;
    logic [15:0] wd_b, rdat_b, bwd_b, brd_b;

    cpu_bus_unit #(.DATA_W(16), .ADDR_W(12)) u_b (
        .clk(clk), .reset(rst_b), .cmd_valid(cv_b), .cmd_ready(crdy_b), .cmd_op(op_b),
        .cmd_addr(addr_b), .cmd_wdata(wd_b), .rsp_valid(rv_b), .rsp_data(rdat_b),
        .rsp_err(rerr_b), .pc(pc_b), .sp(sp_b), .bus_addr(baddr_b), .bus_wdata(bwd_b),
        .bus_rd(rd_b), .bus_wr(wr_b), .bus_io(io_b), .bus_rdata(brd_b), .bus_ack(ack_b));

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state for instance A, plus the device's own memory image.
    logic [7:0] m_pc, m_sp, m_rsp;
    logic [7:0] ref_mem [512];
    logic [7:0] dev_mem [512];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one command on A, act as the device with 'delay' wait cycles, check the outcome.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wd,
                          input int delay, input bit noise);
        logic [7:0] e_addr, e_data, e_pc, e_sp;
        bit e_rd, e_wr, e_io, e_tmo, got, ph_ok;
        int e_lat, n, strobes;
        e_rd = (op == OP_FETCH) || (op == OP_LOAD) || (op == OP_POP) || (op == OP_IN);
        e_wr = (op == OP_STORE) || (op == OP_PUSH) || (op == OP_OUT);
        e_io = (op == OP_IN) || (op == OP_OUT);
        e_addr = (op == OP_FETCH) ? m_pc : (op == OP_PUSH) ? m_sp :
                 (op == OP_POP) ? 8'(m_sp + 1) : addr;
        e_pc = m_pc;
        e_sp = m_sp;
        e_tmo = (op != OP_JUMP) && (MAXW != 0) && (delay >= MAXW);
        if (op == OP_JUMP) begin
            e_lat = 1; e_pc = addr; e_data = m_rsp;
        end else if (e_tmo) begin
            e_lat = MAXW + 1; e_data = 8'h00;
        end else begin
            e_lat = delay + 2;
            e_data = e_rd ? ref_mem[{e_io, e_addr}] : 8'h00;
            if (e_wr) ref_mem[{e_io, e_addr}] = wd;
            if (op == OP_FETCH) e_pc = m_pc + 8'd1;
            if (op == OP_PUSH)  e_sp = m_sp - 8'd1;
            if (op == OP_POP)   e_sp = m_sp + 8'd1;
        end

        chk("cmd_ready_idle", 32'(crdy_a), 32'd1);
        cv_a = 1'b1; op_a = op; addr_a = addr; wd_a = wd;
        @(posedge clk);
        @(negedge clk);
        cv_a = 1'b0;
        n = 1; strobes = 0; got = 0; ph_ok = 1;
        if (noise) begin
            cv_a = 1'($urandom_range(0, 1)); op_a = 3'($urandom_range(0, 7)); addr_a = 8'($urandom);
        end
        while (n <= 40 && !got) begin
            if (rv_a) got = 1;
            else begin
                if (rd_a || wr_a) begin
                    strobes++;
                    if (rd_a !== e_rd || wr_a !== e_wr || io_a !== e_io || baddr_a !== e_addr ||
                        (e_wr && bwd_a !== wd)) ph_ok = 0;
                    if (strobes - 1 >= delay) begin
                        ack_a = 1'b1;
                        if (rd_a) brd_a = dev_mem[{io_a, baddr_a}];
                        else dev_mem[{io_a, baddr_a}] = bwd_a;
                    end else begin
                        ack_a = 1'b0;
                        brd_a = 8'($urandom);
                    end
                end else ack_a = 1'b0;
                @(negedge clk);
                n++;
                if (noise) begin
                    cv_a = 1'($urandom_range(0, 1)); op_a = 3'($urandom_range(0, 7));
                    addr_a = 8'($urandom);
                end
            end
        end
        cv_a = 1'b0;
        ack_a = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("latency", n, e_lat);
        chk("rsp_data", 32'(rdat_a), 32'(e_data));
        chk("rsp_err", 32'(rerr_a), 32'(e_tmo));
        chk("pc", 32'(pc_a), 32'(e_pc));
        chk("sp", 32'(sp_a), 32'(e_sp));
        chk("strobe_cycles", strobes, (op == OP_JUMP) ? 0 : e_lat - 1);
        chk("strobe_phase", 32'(ph_ok), 32'd1);
        chk("strobes_low_at_rsp", 32'({rd_a, wr_a}), 32'd0);
        m_pc = e_pc; m_sp = e_sp; m_rsp = e_data;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rv_a), 32'd0);
        // Idle-time ack noise must be ignored.
        ack_a = 1'($urandom_range(0, 1));
        brd_a = 8'($urandom);
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready_low", 32'(crdy_a), 32'd0);
        rst_a = 1'b1;
        m_pc = 8'h00; m_sp = 8'hFF; m_rsp = 8'h00;
        @(negedge clk);
    endtask

    // Zero-wait transaction on instance B with given device read data.
    task automatic do_b(input logic [2:0] op, input logic [11:0] addr, input logic [15:0] wd,
                        input logic [15:0] rdv, input logic [11:0] e_addr,
                        input logic [15:0] e_data, input logic [11:0] e_pc, input logic [11:0] e_sp);
        cv_b = 1'b1; op_b = op; addr_b = addr; wd_b = wd;
        @(posedge clk);
        @(negedge clk);
        cv_b = 1'b0;
        chk("b_bus_addr", 32'(baddr_b), 32'(e_addr));
        chk("b_strobe", 32'(rd_b | wr_b), 32'd1);
        ack_b = 1'b1; brd_b = rdv;
        @(negedge clk);
        ack_b = 1'b0;
        chk("b_rsp_valid", 32'(rv_b), 32'd1);
        chk("b_rsp_data", 32'(rdat_b), 32'(e_data));
        chk("b_pc", 32'(pc_b), 32'(e_pc));
        chk("b_sp", 32'(sp_b), 32'(e_sp));
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r, dly;
        rst_a = 1'b0; cv_a = 1'b0; op_a = '0; addr_a = '0; wd_a = '0; ack_a = 1'b0; brd_a = '0;
        rst_b = 1'b0; cv_b = 1'b0; op_b = '0; addr_b = '0; wd_b = '0; ack_b = 1'b0; brd_b = '0;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 8'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[0] = 8'h3C; dev_mem[0] = 8'h3C;
        ref_mem[9'h040] = 8'h77; dev_mem[9'h040] = 8'h77;

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(crdy_a), 32'd0);
        chk("reset_pc", 32'(pc_a), 32'd0);
        chk("reset_sp", 32'(sp_a), 32'hFF);
        chk("reset_strobes", 32'({rd_a, wr_a, io_a}), 32'd0);
        chk("reset_rsp", 32'({rv_a, rerr_a, rdat_a}), 32'd0);
        rst_a = 1'b1;
        m_pc = 8'h00; m_sp = 8'hFF; m_rsp = 8'h00;
        @(negedge clk);

        do_cmd(OP_FETCH, 8'h00, 8'h00, 0, 0);
        do_cmd(OP_PUSH,  8'h00, 8'hA5, 1, 0);
        do_cmd(OP_POP,   8'h00, 8'h00, 0, 0);
        chk("pop_returns_pushed", 32'(rdat_a), 32'hA5);
        do_cmd(OP_LOAD,  8'h40, 8'h00, 3, 0);
        do_cmd(OP_IN,    8'h12, 8'h00, 1000, 0);
        do_cmd(OP_OUT,   8'h34, 8'h5E, 0, 0);
        do_cmd(OP_JUMP,  8'hFF, 8'h00, 0, 1);
        do_cmd(OP_FETCH, 8'h00, 8'h00, 0, 1);
        do_cmd(OP_FETCH, 8'h00, 8'h00, 2, 1);
        do_cmd(OP_POP,   8'h00, 8'h00, 0, 0);
        do_cmd(OP_PUSH,  8'h00, 8'h11, 0, 0);
        do_cmd(OP_LOAD,  8'h20, 8'h00, MAXW - 1, 0);
        do_cmd(OP_LOAD,  8'h21, 8'h00, MAXW, 0);

        // Reset while a STORE is waiting for ack.
        cv_a = 1'b1; op_a = OP_STORE; addr_a = 8'h66; wd_a = 8'h99;
        @(posedge clk);
        @(negedge clk);
        cv_a = 1'b0; ack_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("store_waiting", 32'({wr_a, baddr_a}), 32'h166);
        rst_a = 1'b0;
        @(negedge clk);
        chk("midreq_strobes", 32'({rd_a, wr_a, io_a}), 32'd0);
        chk("midreq_no_rsp", 32'(rv_a), 32'd0);
        chk("midreq_pc_sp", 32'({pc_a, sp_a}), 32'h00FF);
        chk("midreq_bus", 32'({baddr_a, bwd_a}), 32'd0);
        rst_a = 1'b1;
        m_pc = 8'h00; m_sp = 8'hFF; m_rsp = 8'h00;
        repeat (2) begin
            @(negedge clk);
            chk("after_rst_no_rsp", 32'(rv_a), 32'd0);
        end

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            dly = (r < 8) ? (r % 4) : ((r == 8) ? MAXW - 1 : MAXW);
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), dly, 1'($urandom_range(0, 1)));
            if (k == 100) reset_a();
        end

        // Wider configuration.
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_reset_pc_sp", 32'({pc_b, sp_b}), 32'h000FFF);
        chk("b_reset_ready", 32'(crdy_b), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        do_b(OP_FETCH, 12'h000, 16'h0000, 16'h1234, 12'h000, 16'h1234, 12'h001, 12'hFFF);
        do_b(OP_PUSH,  12'h000, 16'hBEEF, 16'hDEAD, 12'hFFF, 16'h0000, 12'h001, 12'hFFE);
        cv_b = 1'b1; op_b = OP_STORE; addr_b = 12'hABC; wd_b = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        cv_b = 1'b0;
        chk("b_store_bus", 32'({wr_b, bwd_b, baddr_b}), 32'h15A5AABC);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_midreq_strobes", 32'({rd_b, wr_b, io_b, rv_b}), 32'd0);
        chk("b_midreq_pc_sp", 32'({pc_b, sp_b}), 32'h000FFF);
        chk("b_midreq_bus", 32'({baddr_b, bwd_b}), 32'd0);
        rst_b = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("b_after_rst_no_rsp", 32'(rv_b), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
